load_writeback_queue: RTL and testbench
=======================================

# load_writeback_queue

Tracks outstanding data-memory loads and returns their results to the register file's load write port (`wload_en`/`wload_reg_a`/`wload_reg_v`). Execute pushes a load descriptor (destination, size, sign, byte offset) at issue. Each in-order memory response pops one descriptor, is aligned and extended to 64 bits, and is written back. A per-register pending mask lets decode interlock on loads that have not yet returned.

## Interface
- `DEPTH`, 4: outstanding-load capacity; power of two, 2..16.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `clk_en` in 1: pipeline advance. While low, all state holds and no handshake completes.
- `issue_valid` in 1: execute presents a load.
- `issue_ready` out 1: `!full`. Does not depend on a same-cycle pop.
- `issue_reg_a` in 5: destination register; 31 = XZR.
- `issue_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `issue_signed` in 1: sign-extend when 1, zero-extend when 0.
- `issue_offset` in 3: byte offset within the 64-bit beat.
- `mem_rvalid` in 1: response valid.
- `mem_rdata` in 64: response beat.
- `mem_rready` out 1: `!empty`.
- `wload_en` out 1: load write enable to the register file.
- `wload_reg_a` out 5: load destination register.
- `wload_reg_v` out 64: load write value.
- `pending_mask` out 32: bit r set if any queued entry targets r (r < 31).
- `outstanding` out $clog2(DEPTH)+1: occupancy.
- `spurious_resp` out 1: sticky; set by `mem_rvalid` while empty.

## Operation
- **Push**: fires on `issue_valid & issue_ready & clk_en`. Writes {reg, size, signed, offset} at the write pointer.
- **Pop**: fires on `mem_rvalid & mem_rready & clk_en` and consumes the head entry.
- **Push and pop in one cycle**: both happen; occupancy is unchanged. Pointers wrap modulo DEPTH.
- **Offset alignment**: the offset is forced aligned to the access size: `off_al = offset & ~((1<<size)-1)`.
- **Data extraction**: `mem_rdata >> (8*off_al)`, masked to 8/16/32/64 bits.
- **Extension**: bit 7/15/31 is replicated when `signed`. Size 3 ignores `signed`.
- **XZR destination**: an entry with reg 31 is popped normally, but `wload_en` stays 0.
- **Pending mask**: OR of one-hot(reg) over valid entries. Bit 31 is always 0.
- **Response while empty**: ignored (no pop, no write) and sets `spurious_resp`. The flag clears only on reset.
- **Reset, including mid-operation**:
  - Pointers are cleared; `outstanding`=0 and `pending_mask`=0.
  - `wload_en`=0, `wload_reg_a`=0, `wload_reg_v`=0, `spurious_resp`=0.
  - Outstanding entries are discarded. Their late responses count as spurious.
- **Ordering**: responses arrive strictly in issue order; there is no ID field.

## Timing
- **Push visibility**: a push in cycle N is visible in `pending_mask`/`outstanding` in N+1.
- **Pop latency**: a pop in cycle N drives `wload_en`=1 with reg/value in N+1, for exactly one enabled cycle.
- **Pending clear**: the pending bit clears in N+1. The register file forwards the `wload` value combinationally, so a read in N+1 sees the new data.
- **Back-to-back pops**: pops in N and N+1 give `wload_en` high in N+1 and N+2 with the respective values.
- **`clk_en` low**: while `clk_en` is low with `wload_en`=1, the output registers hold. The write therefore lands exactly once, in the first enabled cycle.
- **Full**: when full, `issue_ready`=0 even if a pop occurs that cycle. The push is accepted the following cycle.

## Configuration
- `LOAD_WB_BYPASS_EN` undefined:
  - `wload_*` outputs are registered; latency from pop to `wload_en` is 1 cycle.
- `LOAD_WB_BYPASS_EN` defined:
  - `wload_en`/`wload_reg_a`/`wload_reg_v` are driven combinationally from the popping entry and `mem_rdata` in cycle N.
  - `wload_en = pop & (reg != 31)`.
  - Output registers are removed.
  - The pending bit still clears in N+1.

## Test plan
- **Basic pop**: push {reg 5, size 3, offset 0}, respond `0x1122334455667788` -> next cycle `wload_en`=1, `wload_reg_a`=5, `wload_reg_v`=`0x1122334455667788`; `pending_mask[5]` 1 then 0.
- **Byte extension**: push {reg 2, size 0, signed 1, offset 6}, respond `0x0080000000000000` -> `wload_reg_v`=`0xFFFFFFFFFFFFFF80`. Repeat with signed 0 -> `0x80`.
- **Full and wrap**: fill DEPTH=4 with regs 1..4 -> `issue_ready`=0, `outstanding`=4. Pop with simultaneous `issue_valid` -> not accepted until next cycle. Pop all -> writes in order 1,2,3,4 and pointers wrap correctly.
- **XZR**: push reg 31 and respond -> entry consumed, `outstanding` decrements, `wload_en` stays 0, `pending_mask`=0.
- **Stall and spurious**: `clk_en`=0 for 3 cycles right after a pop -> `wload_en` held, single register-file write. `mem_rvalid` while empty -> `spurious_resp`=1 until reset.
- **Reset mid-operation**: 3 loads outstanding, assert `reset` -> all outputs 0. The next response sets `spurious_resp` and produces no `wload_en`.

Source files
------------

// File: rtl/load_writeback_queue_if.sv
// Load write-back queue bus: issue channel, memory response channel, register-file load port
// and status. The queue itself connects through the slave modport.
interface load_writeback_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            issue_valid;
  logic            issue_ready;
  logic [4:0]      issue_reg_a;
  logic [1:0]      issue_size;
  logic            issue_signed;
  logic [2:0]      issue_offset;

  logic            mem_rvalid;
  logic            mem_rready;
  logic [63:0]     mem_rdata;

  logic            wload_en;
  logic [4:0]      wload_reg_a;
  logic [63:0]     wload_reg_v;

  logic [31:0]     pending_mask;
  logic [CntW-1:0] outstanding;
  logic            spurious_resp;

  modport master (
    output issue_valid, issue_reg_a, issue_size, issue_signed, issue_offset,
    output mem_rvalid, mem_rdata,
    input  issue_ready, mem_rready,
    input  wload_en, wload_reg_a, wload_reg_v,
    input  pending_mask, outstanding, spurious_resp
  );

  modport slave (
    input  issue_valid, issue_reg_a, issue_size, issue_signed, issue_offset,
    input  mem_rvalid, mem_rdata,
    output issue_ready, mem_rready,
    output wload_en, wload_reg_a, wload_reg_v,
    output pending_mask, outstanding, spurious_resp
  );
endinterface

// File: rtl/load_writeback_queue.sv
// In-order outstanding-load tracker feeding the register-file load write port.
// Define LOAD_WB_BYPASS_EN to drive wload_* combinationally from the popping entry.
module load_writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   clk_en,
  load_writeback_queue_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Descriptor storage; only r_valid and the pointers need reset
  logic [4:0]       r_reg  [DEPTH];
  logic [1:0]       r_size [DEPTH];
  logic             r_sgn  [DEPTH];
  logic [2:0]       r_off  [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             r_spur;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_spur;
  logic             w_wen;
  logic [DEPTH-1:0] w_valid_d;
  logic [4:0]       w_h_reg;
  logic [1:0]       w_h_size;
  logic             w_h_sgn;
  logic [2:0]       w_h_off;
  logic [2:0]       w_off_al;
  logic [63:0]      w_shifted;
  logic [63:0]      w_ext;
  logic [31:0]      w_pending;

  assign w_full  = (r_count == CntW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = clk_en & bus.issue_valid & ~w_full;
  assign w_pop   = clk_en & bus.mem_rvalid & ~w_empty;
  assign w_spur  = clk_en & bus.mem_rvalid & w_empty;

  assign w_h_reg  = r_reg[r_rptr];
  assign w_h_size = r_size[r_rptr];
  assign w_h_sgn  = r_sgn[r_rptr];
  assign w_h_off  = r_off[r_rptr];
  assign w_wen    = w_pop & (w_h_reg != 5'd31);

  always_comb begin
    unique case (w_h_size)
      2'd0:    w_off_al = w_h_off;
      2'd1:    w_off_al = {w_h_off[2:1], 1'b0};
      2'd2:    w_off_al = {w_h_off[2], 2'b00};
      default: w_off_al = 3'd0;
    endcase
  end

  assign w_shifted = bus.mem_rdata >> {w_off_al, 3'b000};

  always_comb begin
    unique case (w_h_size)
      2'd0:    w_ext = {{56{w_h_sgn & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_ext = {{48{w_h_sgn & w_shifted[15]}}, w_shifted[15:0]};
      2'd2:    w_ext = {{32{w_h_sgn & w_shifted[31]}}, w_shifted[31:0]};
      default: w_ext = w_shifted;
    endcase
  end

  // Push never targets the popped slot: push is blocked when full, pop when empty
  always_comb begin
    w_valid_d = r_valid;
    if (w_pop) begin
      w_valid_d[r_rptr] = 1'b0;
    end
    if (w_push) begin
      w_valid_d[r_wptr] = 1'b1;
    end
  end

  always_comb begin
    w_pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) begin
        w_pending[r_reg[i]] = 1'b1;
      end
    end
    w_pending[31] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_reg[r_wptr]  <= bus.issue_reg_a;
      r_size[r_wptr] <= bus.issue_size;
      r_sgn[r_wptr]  <= bus.issue_signed;
      r_off[r_wptr]  <= bus.issue_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_spur  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      r_valid <= w_valid_d;
      if (w_spur) begin
        r_spur <= 1'b1;
      end
    end
  end

`ifdef LOAD_WB_BYPASS_EN
  assign bus.wload_en    = w_wen;
  assign bus.wload_reg_a = w_wen ? w_h_reg : 5'd0;
  assign bus.wload_reg_v = w_wen ? w_ext : 64'd0;
`else
  logic        r_wload_en;
  logic [4:0]  r_wload_reg_a;
  logic [63:0] r_wload_reg_v;

  // Held while clk_en is low so the register file takes the write exactly once
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wload_en    <= 1'b0;
      r_wload_reg_a <= '0;
      r_wload_reg_v <= '0;
    end else if (clk_en) begin
      r_wload_en <= w_wen;
      if (w_wen) begin
        r_wload_reg_a <= w_h_reg;
        r_wload_reg_v <= w_ext;
      end
    end
  end

  assign bus.wload_en    = r_wload_en;
  assign bus.wload_reg_a = r_wload_reg_a;
  assign bus.wload_reg_v = r_wload_reg_v;
`endif

  assign bus.issue_ready   = ~w_full;
  assign bus.mem_rready    = ~w_empty;
  assign bus.pending_mask  = w_pending;
  assign bus.outstanding   = r_count;
  assign bus.spurious_resp = r_spur;

endmodule

// File: tb/tb_load_writeback_queue.sv
// Randomized scoreboard bench for load_writeback_queue (default registered-output build).
module tb_load_writeback_queue;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [4:0] ra;
    logic [1:0] sz;
    bit         sg;
    logic [2:0] of;
  } desc_t;

  typedef struct {
    logic [4:0]  ra;
    logic [63:0] v;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;

  load_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

  load_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  desc_t mq[$];
  wr_t   exp_q[$];
  bit    m_spur = 1'b0;
  bit    m_init = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference load result: pick the aligned field, then zero/sign extend
  function automatic logic [63:0] ref_load(input logic [63:0] data, input int sz, input bit sg,
                                           input int of);
    int          nb;
    int          off_al;
    logic [63:0] v;
    logic [63:0] keep;
    nb     = 1 << sz;
    off_al = (of / nb) * nb;
    v      = data >> (8 * off_al);
    if (nb < 8) begin
      keep = (64'd1 << (8 * nb)) - 64'd1;
      v    = v & keep;
      if (sg && v[8*nb-1]) v = v | ~keep;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].ra != 5'd31) m[mq[i].ra] = 1'b1;
    return m;
  endfunction

  // Monitor: a register-file write lands on each edge where wload_en and clk_en are both high
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.wload_en === 1'b1 && clk_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wload_unexpected: got write reg %0d value 0x%0h, expected none",
                   bus.wload_reg_a, bus.wload_reg_v);
        end else begin
          e = exp_q.pop_front();
          check("wload_reg_a", 64'(bus.wload_reg_a), 64'(e.ra));
          check("wload_reg_v", bus.wload_reg_v, e.v);
        end
      end
    end
  end

  task automatic step(input bit iv, input logic [4:0] ra, input logic [1:0] sz, input bit sg,
                      input logic [2:0] of, input bit rv, input logic [63:0] rd, input bit ce,
                      input bit rst);
    bit    push;
    bit    pop;
    bit    spur;
    desc_t d;
    wr_t   w;
    reset            = rst;
    clk_en           = ce;
    bus.issue_valid  = iv;
    bus.issue_reg_a  = ra;
    bus.issue_size   = sz;
    bus.issue_signed = sg;
    bus.issue_offset = of;
    bus.mem_rvalid   = rv;
    bus.mem_rdata    = rd;
    push = !rst && ce && iv && (mq.size() < DEPTH);
    pop  = !rst && ce && rv && (mq.size() > 0);
    spur = !rst && ce && rv && (mq.size() == 0);
    if (m_init) begin
      check("issue_ready", 64'(bus.issue_ready), 64'(mq.size() < DEPTH));
      check("mem_rready", 64'(bus.mem_rready), 64'(mq.size() > 0));
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_spur = 1'b0;
      m_init = 1'b1;
    end else begin
      if (pop) begin
        d = mq.pop_front();
        if (d.ra != 5'd31) begin
          w.ra = d.ra;
          w.v  = ref_load(rd, int'(d.sz), d.sg, int'(d.of));
          exp_q.push_back(w);
        end
      end
      if (push) begin
        d.ra = ra; d.sz = sz; d.sg = sg; d.of = of;
        mq.push_back(d);
      end
      if (spur) m_spur = 1'b1;
    end
    #1;
    if (m_init) begin
      check("outstanding", 64'(bus.outstanding), 64'(mq.size()));
      check("pending_mask", 64'(bus.pending_mask), 64'(model_mask()));
      check("spurious_resp", 64'(bus.spurious_resp), 64'(m_spur));
    end
    if (rst) begin
      check("rst_wload_en", 64'(bus.wload_en), 64'd0);
      check("rst_wload_reg_a", 64'(bus.wload_reg_a), 64'd0);
      check("rst_wload_reg_v", bus.wload_reg_v, 64'd0);
    end
  endtask

  task automatic idle(input bit ce);
    step(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, ce, 1'b0);
  endtask

  task automatic push_ld(input logic [4:0] ra, input logic [1:0] sz, input bit sg,
                         input logic [2:0] of);
    step(1'b1, ra, sz, sg, of, 1'b0, 64'd0, 1'b1, 1'b0);
  endtask

  task automatic resp(input logic [63:0] rd);
    step(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 1'b1, rd, 1'b1, 1'b0);
  endtask

  initial begin
    step(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b1);
    step(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b1);

    // Basic dword pop
    push_ld(5'd5, 2'd3, 1'b0, 3'd0);
    check("basic_pend_set", 64'(bus.pending_mask[5]), 64'd1);
    resp(64'h1122_3344_5566_7788);
    check("basic_en", 64'(bus.wload_en), 64'd1);
    check("basic_reg", 64'(bus.wload_reg_a), 64'd5);
    check("basic_val", bus.wload_reg_v, 64'h1122_3344_5566_7788);
    check("basic_pend_clr", 64'(bus.pending_mask[5]), 64'd0);

    // Byte at offset 6, signed then unsigned
    push_ld(5'd2, 2'd0, 1'b1, 3'd6);
    resp(64'h0080_0000_0000_0000);
    check("byte_signed", bus.wload_reg_v, 64'hFFFF_FFFF_FFFF_FF80);
    push_ld(5'd2, 2'd0, 1'b0, 3'd6);
    resp(64'h0080_0000_0000_0000);
    check("byte_unsigned", bus.wload_reg_v, 64'h0000_0000_0000_0080);

    // Full, pop with blocked push, then wrap
    for (int r = 1; r <= 4; r++) push_ld(5'(r), 2'd2, 1'b1, 3'(r));
    check("full_ready", 64'(bus.issue_ready), 64'd0);
    check("full_count", 64'(bus.outstanding), 64'd4);
    step(1'b1, 5'd9, 2'd1, 1'b1, 3'd3, 1'b1, 64'hDEAD_BEEF_8765_4321, 1'b1, 1'b0);
    check("full_pop_count", 64'(bus.outstanding), 64'd3);
    check("full_first_reg", 64'(bus.wload_reg_a), 64'd1);
    step(1'b1, 5'd9, 2'd1, 1'b1, 3'd3, 1'b1, 64'hCAFE_F00D_1234_ABCD, 1'b1, 1'b0);
    check("full_push_late", 64'(bus.pending_mask[9]), 64'd1);
    for (int k = 0; k < 4; k++) resp({$urandom(), $urandom()});
    idle(1'b1);

    // XZR destination
    push_ld(5'd31, 2'd3, 1'b0, 3'd0);
    check("xzr_pend", 64'(bus.pending_mask), 64'd0);
    resp(64'h5555_AAAA_5555_AAAA);
    check("xzr_en", 64'(bus.wload_en), 64'd0);
    check("xzr_count", 64'(bus.outstanding), 64'd0);

    // Stall right after a pop: single write in the first enabled cycle
    push_ld(5'd7, 2'd1, 1'b1, 3'd2);
    resp(64'h0000_0000_8001_0000);
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      check("stall_hold", 64'(bus.wload_en), 64'd1);
    end
    idle(1'b1);
    check("stall_release", 64'(bus.wload_en), 64'd0);

    // Response while empty
    resp(64'h1);
    check("spurious_set", 64'(bus.spurious_resp), 64'd1);
    idle(1'b1);

    // Reset with loads outstanding
    for (int r = 10; r <= 12; r++) push_ld(5'(r), 2'd3, 1'b0, 3'd0);
    step(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b1);
    resp(64'h7777_7777_7777_7777);
    check("late_resp_spur", 64'(bus.spurious_resp), 64'd1);
    check("late_resp_no_wr", 64'(bus.wload_en), 64'd0);
    step(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit          iv;
      bit          rv;
      logic [4:0]  ra;
      iv = ($urandom_range(0, 1) == 1);
      rv = (mq.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 60) == 0);
      ra = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      step(iv, ra, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), rv, {$urandom(), $urandom()},
           ($urandom_range(0, 6) != 0), ($urandom_range(0, 299) == 0));
    end

    for (int k = 0; k < 64 && mq.size() > 0; k++) resp({$urandom(), $urandom()});
    idle(1'b1);
    idle(1'b1);
    check("drain_writes", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
